// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: multi-cycle controller that runs one calculator
// instruction at a time against the shared register bank. It fetches
// operands through the single bank read port, computes the result in a
// small internal ALU and writes it back through the bank write port.
//
// Handshake: an instruction is accepted on a rising edge where start=1
// and busy=0; op/rd/ra/rb/imm are sampled only on that edge. start while
// busy=1 is dropped, not queued. done and rf_we pulse together for one
// cycle, and busy falls on the edge that ends that cycle.
module calc_op_sequencer #(
    parameter  int DATA_W = 8,
    parameter  int NREGS  = 8,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [DATA_W-1:0] imm,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              zero,
    output logic              carry,
    output logic [2:0]        state_dbg
);

    // Instruction opcodes
    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_LOADI = 3'd4;
    localparam logic [2:0] OP_MOV   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ_A = 3'd1,
        READ_B = 3'd2,
        EXEC   = 3'd3,
        WRITE  = 3'd4
    } state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] rb_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] res_q;

    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic [DATA_W:0]   alu_wide;

    assign state_dbg = state;

    // ALU: result and carry/borrow for the latched op and operands
    always_comb begin
        alu_wide  = '0;
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_wide  = {1'b0, a_q} + {1'b0, b_q};
                alu_res   = alu_wide[DATA_W-1:0];
                alu_carry = alu_wide[DATA_W];
            end
            OP_SUB: begin
                // the extra top bit of the wide difference is the borrow (A<B)
                alu_wide  = {1'b0, a_q} - {1'b0, b_q};
                alu_res   = alu_wide[DATA_W-1:0];
                alu_carry = alu_wide[DATA_W];
            end
            OP_AND:   alu_res = a_q & b_q;
            OP_OR:    alu_res = a_q | b_q;
            OP_LOADI: alu_res = imm_q;
            OP_MOV:   alu_res = a_q;
            default:  alu_res = '0;
        endcase
    end

    // Sequencer FSM with registered outputs; async reset aborts any
    // instruction, so a pending rf_we drops the moment reset rises
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            rb_q     <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            rf_raddr <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            zero     <= 1'b0;
            carry    <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    rf_raddr <= '0;
                    if (start) begin
                        op_q  <= op;
                        rd_q  <= rd;
                        rb_q  <= rb;
                        imm_q <= imm;
                        err   <= 1'b0;
                        case (op)
                            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV: begin
                                state    <= READ_A;
                                busy     <= 1'b1;
                                // address presented during READ_A
                                rf_raddr <= ra;
                            end
                            OP_LOADI: begin
                                state <= EXEC;
                                busy  <= 1'b1;
                            end
                            default: begin
                                err <= 1'b1;
                            end
                        endcase
                    end
                end
                READ_A: begin
                    a_q <= rf_rdata;
                    if (op_q == OP_MOV) begin
                        state    <= EXEC;
                        rf_raddr <= '0;
                    end else begin
                        state    <= READ_B;
                        rf_raddr <= rb_q;
                    end
                end
                READ_B: begin
                    b_q      <= rf_rdata;
                    state    <= EXEC;
                    rf_raddr <= '0;
                end
                EXEC: begin
                    // flags and write port change together, in step with done
                    res_q    <= alu_res;
                    rf_wdata <= alu_res;
                    rf_waddr <= rd_q;
                    zero     <= (alu_res == '0);
                    carry    <= alu_carry;
                    rf_we    <= 1'b1;
                    done     <= 1'b1;
                    state    <= WRITE;
                end
                WRITE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    rf_raddr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb_calc_op_sequencer: directed and randomized checks of the calculator
// sequencer against an instruction-level reference model of the bank.
module tb_calc_op_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [2:0] rd, ra, rb;
    logic [7:0] imm;
    logic [2:0] rf_raddr;
    logic [7:0] rf_rdata;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       busy, done, err, zero, carry;
    logic [2:0] state_dbg;

    calc_op_sequencer #(.DATA_W(8), .NREGS(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rd(rd), .ra(ra), .rb(rb), .imm(imm),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .done(done), .err(err), .zero(zero), .carry(carry),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- register bank ----------------
    logic [7:0] bank [8];
    assign rf_rdata = bank[rf_raddr];
    always @(posedge clk) if (rf_we) bank[rf_waddr] <= rf_wdata;

    // ---------------- reference model state ----------------
    logic [7:0] mdl [8];
    logic       f_zero, f_carry;

    int n_tests = 0;
    int n_fail  = 0;
    int n_writes = 0;

    // scoreboard entries: {zero, carry, waddr[2:0], wdata[7:0]}
    logic [12:0] exp_q [$];
    logic [12:0] e;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // {zero, carry, result} of one instruction from plain arithmetic
    function automatic logic [9:0] model(input logic [2:0] o, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] im);
        int s;
        logic [7:0] r;
        logic c;
        r = 8'h00;
        c = 1'b0;
        case (o)
            3'd0: begin s = int'(a) + int'(b); r = 8'(s % 256); c = (s > 255); end
            3'd1: begin s = int'(a) - int'(b); r = 8'((s + 256) % 256); c = (s < 0); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = im;
            3'd5: r = a;
            default: r = 8'h00;
        endcase
        return {(r == 8'h00), c, r};
    endfunction

    function automatic int latency(input logic [2:0] o);
        if (o == 3'd4) return 2;
        if (o == 3'd5) return 3;
        return 4;
    endfunction

    // write monitor: every rf_we must match the head of the expected queue
    always @(negedge clk) begin
        if (!reset && rf_we) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("wr_addr", rf_waddr, e[10:8]);
                check_eq("wr_data", rf_wdata, e[7:0]);
                check_eq("wr_zero", zero, e[12]);
                check_eq("wr_carry", carry, e[11]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_we", rf_we, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_zero", zero, 0);
        check_eq("rst_carry", carry, 0);
        check_eq("rst_raddr", rf_raddr, 0);
        check_eq("rst_waddr", rf_waddr, 0);
        check_eq("rst_wdata", rf_wdata, 0);
        reset = 1'b0;
        f_zero = 1'b0;
        f_carry = 1'b0;
    endtask

    // issue one instruction and check it cycle by cycle; poke keeps start
    // asserted with junk fields while busy (must be ignored)
    task automatic run_op(input logic [2:0] o, input logic [2:0] d, input logic [2:0] a_i,
                          input logic [2:0] b_i, input logic [7:0] im, input bit poke);
        logic [9:0] m;
        int lat;
        logic [2:0] exp_raddr;
        @(negedge clk);
        op = o; rd = d; ra = a_i; rb = b_i; imm = im; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (o >= 3'd6) begin
            start = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                if (k > 1) @(negedge clk);
                check_eq("inv_err", err, 1);
                check_eq("inv_busy", busy, 0);
                check_eq("inv_we", rf_we, 0);
                check_eq("inv_zero", zero, f_zero);
                check_eq("inv_carry", carry, f_carry);
            end
        end else begin
            m = model(o, mdl[a_i], mdl[b_i], im);
            lat = latency(o);
            exp_q.push_back({m[9], m[8], d, m[7:0]});
            for (int k = 1; k <= lat + 1; k++) begin
                if (k > 1) @(negedge clk);
                check_eq("busy", busy, (k <= lat));
                check_eq("rf_we", rf_we, (k == lat));
                check_eq("done", done, (k == lat));
                check_eq("err_clear", err, 0);
                exp_raddr = 3'd0;
                if (k == 1 && o != 3'd4) exp_raddr = a_i;
                if (k == 2 && o <= 3'd3) exp_raddr = b_i;
                check_eq("rf_raddr", rf_raddr, exp_raddr);
                if (k == lat) begin
                    f_zero = m[9];
                    f_carry = m[8];
                    mdl[d] = m[7:0];
                end
                check_eq("zero", zero, f_zero);
                check_eq("carry", carry, f_carry);
                if (k == lat + 1) check_eq("wdata_hold", rf_wdata, m[7:0]);
                start = poke && (k < lat);
                op = 3'($urandom_range(0, 7));
                rd = 3'($urandom_range(0, 7));
                ra = 3'($urandom_range(0, 7));
                rb = 3'($urandom_range(0, 7));
                imm = 8'($urandom_range(0, 255));
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [9:0] m;
        int w0;
        reset = 1'b1; start = 1'b0; op = '0; rd = '0; ra = '0; rb = '0; imm = '0;
        f_zero = 1'b0; f_carry = 1'b0;
        do_reset();

        // preload every register through the DUT itself
        for (int i = 0; i < 8; i++) run_op(3'd4, 3'(i), 3'd0, 3'd0, 8'($urandom_range(0, 255)), 1'b0);

        // ADD r3 = r1 + r2 = 5 + 3
        run_op(3'd4, 3'd1, 3'd0, 3'd0, 8'd5, 1'b0);
        run_op(3'd4, 3'd2, 3'd0, 3'd0, 8'd3, 1'b0);
        run_op(3'd0, 3'd3, 3'd1, 3'd2, 8'd0, 1'b0);
        @(negedge clk);
        check_eq("add_r3", bank[3], 8'd8);

        // SUB underflow with rd aliasing ra: r1 = 3 - 5
        run_op(3'd4, 3'd1, 3'd0, 3'd0, 8'd3, 1'b0);
        run_op(3'd4, 3'd2, 3'd0, 3'd0, 8'd5, 1'b0);
        run_op(3'd1, 3'd1, 3'd1, 3'd2, 8'd0, 1'b0);
        @(negedge clk);
        check_eq("sub_r1", bank[1], 8'hFE);
        check_eq("sub_carry", carry, 1);
        check_eq("sub_zero", zero, 0);

        // ADD 0xFF + 0x01 wraps to zero with carry
        run_op(3'd4, 3'd6, 3'd0, 3'd0, 8'hFF, 1'b0);
        run_op(3'd4, 3'd7, 3'd0, 3'd0, 8'h01, 1'b0);
        run_op(3'd0, 3'd0, 3'd6, 3'd7, 8'd0, 1'b0);
        check_eq("wrap_zero", zero, 1);
        check_eq("wrap_carry", carry, 1);

        // back-to-back: LOADI r4=A5 then MOV r5=r4 with start held high
        @(negedge clk);
        op = 3'd4; rd = 3'd4; ra = 3'd0; rb = 3'd0; imm = 8'hA5; start = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 3'd4, 8'hA5});
        exp_q.push_back({1'b0, 1'b0, 3'd5, 8'hA5});
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) begin op = 3'd5; rd = 3'd5; ra = 3'd4; imm = 8'h00; end
            check_eq("b2b_we", rf_we, (k == 2 || k == 6));
            check_eq("b2b_busy", busy, (k != 3 && k <= 6));
            if (k == 4) start = 1'b0;
        end
        mdl[4] = 8'hA5; mdl[5] = 8'hA5; f_zero = 1'b0; f_carry = 1'b0;
        check_eq("b2b_r5", bank[5], 8'hA5);

        // invalid op sets err; the next valid accept clears it
        run_op(3'd6, 3'd2, 3'd0, 3'd0, 8'd0, 1'b0);
        run_op(3'd0, 3'd2, 3'd4, 3'd5, 8'd0, 1'b0);
        run_op(3'd7, 3'd3, 3'd0, 3'd0, 8'd0, 1'b0);

        // start pulses while busy are ignored: exactly one write
        w0 = n_writes;
        run_op(3'd3, 3'd6, 3'd1, 3'd2, 8'd0, 1'b1);
        repeat (3) @(negedge clk);
        check_eq("ignored_starts", n_writes - w0, 1);

        // randomized instruction stream
        for (int i = 0; i < 40; i++) begin
            logic [2:0] o;
            o = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            run_op(o, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        // reset during WRITE: the write is aborted and r3 is untouched
        @(negedge clk);
        op = 3'd0; rd = 3'd3; ra = 3'd1; rb = 3'd2; start = 1'b1;
        m = model(3'd0, mdl[1], mdl[2], 8'd0);
        exp_q.push_back({m[9], m[8], 3'd3, m[7:0]});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("pre_rst_we", rf_we, 1);
        #1 reset = 1'b1;
        #1;
        check_eq("midrst_we", rf_we, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_zero", zero, 0);
        check_eq("midrst_carry", carry, 0);
        check_eq("midrst_done", done, 0);
        @(posedge clk);
        #1;
        check_eq("midrst_r3", bank[3], mdl[3]);
        @(negedge clk);
        reset = 1'b0;
        f_zero = 1'b0; f_carry = 1'b0;
        exp_q.delete();

        // one more instruction after the abort, then compare the whole bank
        run_op(3'd0, 3'd3, 3'd1, 3'd2, 8'd0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 8; i++) check_eq($sformatf("bank_r%0d", i), bank[i], mdl[i]);
        check_eq("exp_q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
